// File: rtl/fifo_flops_param.sv
// Single-clock flop-based FIFO with arbitrary depth, occupancy count, thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered Dout.
module fifo_flops_param #(
  parameter int depth    = 16,
  parameter int bits     = 8,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
  input  logic [bits-1:0]              Din,
  output logic [bits-1:0]              Dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            push_ok;
  logic            pop_ok;

  // Modulo-depth increment so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CW'(1);
    else if (!push_ok && pop_ok)
      count_nxt = count - CW'(1);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= Din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)
        rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_nxt;
      full         <= (count_nxt == CW'(depth));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      // A fresh error on the clearing edge wins over clr_err.
      overflow     <= (push & ~push_ok) | (overflow & ~clr_err);
      underflow    <= (pop & ~pop_ok) | (underflow & ~clr_err);
    end
  end

`ifdef FIFO_FWFT_EN
  assign Dout = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      Dout <= '0;
    else if (pop_ok)
      Dout <= mem[rd_ptr];
  end
`endif

endmodule
